// File: rtl/adc_capture_if.sv
// Readout stream of the ADC capture block: sample, valid/ready, end-of-window.
interface adc_capture_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] Dout;
    logic              Dout_Valid;
    logic              Dout_Ready;
    logic              Dout_Last;

    modport master (output Dout, output Dout_Valid, output Dout_Last, input Dout_Ready);
    modport slave  (input Dout, input Dout_Valid, input Dout_Last, output Dout_Ready);
endinterface

// File: rtl/adc_capture.sv
// ADC capture: decimates a registered ADC bus into a circular RAM, completes a
// fixed-length window around a level/edge trigger, then streams it oldest-first.
module adc_capture #(
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int DECIM_W = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [DATA_W-1:0]  ADC_Data,
    input  logic               Start,
    input  logic [DECIM_W-1:0] Decim,
    input  logic               Trig_En,
    input  logic               Trig_Edge,
    input  logic [DATA_W-1:0]  Trig_Level,
    input  logic [ADDR_W-1:0]  Pre_Len,
    output logic               Busy,
    output logic               Triggered,
    output logic               Done,
    adc_capture_if.master      dout_if
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_READ} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  adc_q, prev_q, rdata;
    logic [DECIM_W-1:0] dec_q, dec_cnt;
    logic               trig_en_q, trig_edge_q, first_q;
    logic [DATA_W-1:0]  level_q;
    logic [ADDR_W-1:0]  pre_q, wptr, rd_addr;
    logic [CNT_W-1:0]   cnt, rd_cnt;
    logic               valid_q, last_q;

    logic               capturing, keep, edge_hit, trig_fire, start_ok;
    logic               rd_en, xfer, last_xfer, enter_read;
    logic [DATA_W-1:0]  prev_v;
    logic [CNT_W-1:0]   cnt_inc, post_len;

    // Qualifiers: sample keep strobe, trigger detection and readout handshake.
    always_comb begin
        capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
        keep      = capturing && (dec_cnt == '0);
        prev_v    = first_q ? adc_q : prev_q;
        edge_hit  = trig_edge_q ? ((prev_v >= level_q) && (adc_q < level_q))
                                : ((prev_v < level_q) && (adc_q >= level_q));
        trig_fire = (state == S_ARMED) && keep && (!trig_en_q || edge_hit);
        cnt_inc   = cnt + CNT_W'(1);
        post_len  = CNT_W'(DEPTH) - {1'b0, pre_q};
        rd_en     = (state == S_READ) && (!valid_q || dout_if.Dout_Ready)
                    && (rd_cnt != CNT_W'(DEPTH));
        xfer      = valid_q && dout_if.Dout_Ready;
        last_xfer = xfer && last_q;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    start_ok = 1'b1;
                    state_nx = (Pre_Len == '0) ? S_ARMED : S_PRE;
                end
            end
            S_PRE:   if (keep && (cnt_inc == {1'b0, pre_q})) state_nx = S_ARMED;
            S_ARMED: if (trig_fire) state_nx = (post_len == CNT_W'(1)) ? S_READ : S_POST;
            S_POST:  if (keep && (cnt_inc == post_len)) state_nx = S_READ;
            S_READ:  if (last_xfer) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        enter_read = (state_nx == S_READ) && (state != S_READ);
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Sample RAM write port; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (keep) mem[wptr] <= adc_q;
    end

    // Capture datapath: input register, settings, decimation, pointers, readout.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            adc_q       <= '0;
            prev_q      <= '0;
            rdata       <= '0;
            dec_q       <= '0;
            dec_cnt     <= '0;
            trig_en_q   <= 1'b0;
            trig_edge_q <= 1'b0;
            level_q     <= '0;
            pre_q       <= '0;
            first_q     <= 1'b0;
            wptr        <= '0;
            rd_addr     <= '0;
            cnt         <= '0;
            rd_cnt      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            Triggered   <= 1'b0;
            Done        <= 1'b0;
        end else begin
            adc_q <= ADC_Data;
            Done  <= 1'b0;
            if (start_ok) begin
                dec_q       <= Decim;
                trig_en_q   <= Trig_En;
                trig_edge_q <= Trig_Edge;
                level_q     <= Trig_Level;
                pre_q       <= Pre_Len;
                wptr        <= '0;
                dec_cnt     <= '0;
                cnt         <= '0;
                first_q     <= 1'b1;
                Triggered   <= 1'b0;
            end else if (keep) begin
                dec_cnt <= dec_q;
                wptr    <= wptr + ADDR_W'(1);
                prev_q  <= adc_q;
                first_q <= 1'b0;
                // In ARMED only a firing sample matters; it restarts the count as post sample 1.
                cnt     <= (state == S_ARMED) ? CNT_W'(1) : cnt_inc;
            end else if (capturing) begin
                dec_cnt <= dec_cnt - DECIM_W'(1);
            end
            if (trig_fire) Triggered <= 1'b1;
            // The final write lands this cycle, so the oldest sample is one past it.
            if (enter_read) begin
                rd_addr <= wptr + ADDR_W'(1);
                rd_cnt  <= '0;
            end
            if (rd_en) begin
                rdata   <= mem[rd_addr];
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_cnt  <= rd_cnt + CNT_W'(1);
                last_q  <= (rd_cnt == CNT_W'(DEPTH - 1));
                valid_q <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
            if (last_xfer) begin
                Done      <= 1'b1;
                Triggered <= 1'b0;
                last_q    <= 1'b0;
            end
        end
    end

    assign Busy               = (state != S_IDLE);
    assign dout_if.Dout       = rdata;
    assign dout_if.Dout_Valid = valid_q;
    assign dout_if.Dout_Last  = last_q;
endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Receive-side counterpart to the DDS/AD9767 transmit path: samples a parallel ADC bus every clock and keeps every (Decim+1)-th sample.
- Stores kept samples circularly in an internal RAM. After a level/edge trigger it completes a fixed-length capture window.
- Streams the window out oldest-first over a valid/ready handshake, e.g. to a UART or scope front end.
- Used to loop back and verify generated DDS waveforms and phase offsets.

Parameters:
- DATA_W, 14, ADC sample width, offset-binary unsigned.
- ADDR_W, 10, RAM address width.
- DEPTH, 2**ADDR_W, capture window length in samples.
- DECIM_W, 16, decimation counter width.

Ports:
- Clk  in  1  system clock (125 MHz domain); ADC is clocked externally from the same source.
- Reset_n  in  1  reset, asynchronous assert, active-low.
- ADC_Data  in  DATA_W  parallel ADC output, registered once on entry.
- Start  in  1  one-cycle capture request.
- Decim  in  DECIM_W  keep one sample per Decim+1 clocks.
- Trig_En  in  1  0 = trigger immediately when armed.
- Trig_Edge  in  1  0 = rising, 1 = falling.
- Trig_Level  in  DATA_W  trigger threshold, unsigned.
- Pre_Len  in  ADDR_W  samples retained before the trigger sample.
- Busy  out  1  high from Start acceptance until the last readout handshake.
- Triggered  out  1  high from trigger detection until return to IDLE.
- Done  out  1  one-cycle pulse after the last readout handshake.
- Dout  out  DATA_W  readout sample.
- Dout_Valid  out  1  readout valid.
- Dout_Ready  in  1  sink ready.
- Dout_Last  out  1  high with the DEPTH-th readout sample.

Behaviour:
- Reset: state IDLE; all outputs 0; pointers, counters and latched settings 0. RAM contents are not cleared. Reset in any state aborts immediately.
- Start is accepted only in IDLE; it is ignored while Busy.
- On acceptance, latch Decim, Trig_En, Trig_Edge, Trig_Level and Pre_Len. Clear the write pointer and decimation counter. Set Busy.
- Decimation: counter loads 0 at Start. A sample is kept when the counter equals 0; the counter then reloads to the latched Decim and decrements each clock. Decim=0 keeps every registered sample.
- Each kept sample is written at wptr, then wptr increments modulo DEPTH.
- States:
  - PRE: write kept samples until Pre_Len have been written, then go to ARMED. PRE is skipped when Pre_Len=0.
  - ARMED: keep writing circularly. The trigger is evaluated on each kept sample only, and that sample is the trigger sample.
    - Rising edge: prev < Level and cur >= Level.
    - Falling edge: prev >= Level and cur < Level.
    - prev is the previously kept sample. For the first kept sample after Start, prev = cur, so it can never trigger.
    - With Trig_En=0, the first kept sample in ARMED is the trigger sample.
    - On trigger: set Triggered, go to POST. The trigger sample counts as post sample 1.
    - ARMED waits indefinitely; only reset aborts it.
  - POST: write until DEPTH-Pre_Len post samples are written, trigger sample included. Then set rptr = wptr, which is the oldest sample, and go to READ.
  - READ: synchronous RAM read, 1-cycle latency, prefetched so Dout_Valid can assert.
    - Once Dout_Valid is high, Dout and Dout_Last hold stable until Dout_Ready is high.
    - A transfer occurs on Valid & Ready.
    - Back-to-back transfers at 1 per clock must be sustained while Ready stays high.
    - Readout index k = RAM[(rptr+k) mod DEPTH], k = 0..DEPTH-1. The trigger sample is at index Pre_Len.
    - Dout_Last is high on index DEPTH-1. After its transfer: Dout_Valid=0, Busy=0, Triggered=0, Done=1 for one clock, state IDLE.
- No ADC writes occur during READ.
- Pointer arithmetic is modulo DEPTH; wrap-around of wptr in ARMED is normal operation.

Test Plan:
- DEPTH=16, Decim=0, Trig_En=0, Pre_Len=0, ADC_Data = free-running ramp, Ready=1 -> 16 transfers, each value = previous+1, Last on 16th only, Done one-cycle pulse, Busy falls with Done.
- Rising trigger, Level=100, Pre_Len=4, ramp from 0 (DEPTH=16) -> readout starts at 96, index 4 = 100, ends at 111, Triggered high until Done.
- Decim=3, Trig_En=0, ramp -> consecutive readout values differ by exactly 4. Decim=0 rerun -> they differ by 1.
- Falling trigger with constant input 200, Level=100 -> Busy stays 1, Triggered 0, Dout_Valid 0 for 10000 clocks. Then drop input to 50 -> trigger fires and capture completes.
- Random Dout_Ready backpressure during READ -> exactly DEPTH unique, in-order samples; Dout/Last stable while Valid & !Ready; second Start pulse during READ ignored.
- Reset_n pulsed low mid-POST -> all outputs 0 immediately; the next Start runs a complete, correct capture.
